// File: rtl/sample_pkg.sv
// Shared definitions for the sample datapath: default widths, dot-product FSM
// states and the signed saturation helper.
package sample_pkg;

  localparam int DATA_W_DEF  = 13;
  localparam int N_TERMS_DEF = 16;
  localparam int ACC_W_DEF   = 18;
  localparam int OUT_W_DEF   = 13;
  // Working width of the saturation helper; accumulators must not exceed it.
  localparam int SAT_W       = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Clamp a sign-extended value to the signed range of an out_w-bit result.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] a,
    input int unsigned             out_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (32'sd1 <<< (out_w - 32'd1)) - 32'sd1;
    lo = ~hi;
    if (a > hi) begin
      saturate = hi;
    end else if (a < lo) begin
      saturate = lo;
    end else begin
      saturate = a;
    end
  endfunction

endpackage

// File: rtl/sample_sat_relu.sv
// Combinational clamp of the accumulator to the output width. With
// SAMPLE_DOT_ACC_RELU_EN defined, negative clamped results are forced to zero.
module sample_sat_relu
  import sample_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] sat_o
);

  logic signed [SAT_W-1:0] wide_s;
  logic        [OUT_W-1:0] sat_s;

  assign wide_s = {{(SAT_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
  assign sat_s  = OUT_W'(saturate(wide_s, OUT_W));

  // Optional rectification after the clamp.
  always_comb begin
    sat_o = sat_s;
`ifdef SAMPLE_DOT_ACC_RELU_EN
    if (sat_s[OUT_W-1]) begin
      sat_o = {OUT_W{1'b0}};
    end else begin
      sat_o = sat_s;
    end
`endif
  end

endmodule

// File: rtl/sample_dot_acc.sv
// Fixed-length dot-product accumulator with bias preload, saturated output and
// valid/ready handshake. Optional ReLU via SAMPLE_DOT_ACC_RELU_EN.
module sample_dot_acc
  import sample_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [DATA_W-1:0] prod,
  input  logic              prod_valid,
  input  logic              prod_last,
  input  logic [DATA_W-1:0] bias,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_len
);

  localparam int CNT_W = $clog2(N_TERMS + 1);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic        [CNT_W-1:0]  cnt_q, cnt_d;
  logic        [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     err_q, err_d;

  logic                     accept_s;
  logic                     handshake_s;
  logic                     full_s;
  logic                     close_s;
  logic                     len_bad_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  bias_ext_s;
  logic signed [ACC_W-1:0]  base_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic        [OUT_W-1:0]  sat_s;

  assign in_ready    = (state_q != OUT);
  assign busy        = (state_q != IDLE);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err_len     = err_q;

  assign accept_s    = ce & prod_valid & in_ready;
  assign handshake_s = ce & out_valid_q & out_ready;

  // This product completes the nominal term count; a mismatch with
  // prod_last in either direction is a length error.
  assign full_s      = (cnt_q == CNT_W'(N_TERMS - 1));
  assign close_s     = prod_last | full_s;
  assign len_bad_s   = prod_last ^ full_s;

  assign prod_ext_s  = {{(ACC_W-DATA_W){prod[DATA_W-1]}}, prod};
  assign bias_ext_s  = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
  assign base_s      = (state_q == IDLE) ? bias_ext_s : acc_q;
  assign sum_s       = base_s + prod_ext_s;

  sample_sat_relu #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc_i (sum_s),
    .sat_o (sat_s)
  );

  // Next-state and datapath update for the accumulate/present cycle.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    case (state_q)
      IDLE, ACC: begin
        if (accept_s) begin
          acc_d = sum_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (close_s) begin
            state_d     = OUT;
            out_valid_d = 1'b1;
            out_data_d  = sat_s;
            err_d       = err_q | len_bad_s;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = state_q;
        end
      end
      OUT: begin
        if (handshake_s) begin
          out_valid_d = 1'b0;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        cnt_d       = {CNT_W{1'b0}};
      end
    endcase
  end

  // State registers; reset wins over ce, ce low freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= {ACC_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      out_data_q  <= {OUT_W{1'b0}};
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

endmodule
